tt_sweep_ctrl: RTL and testbench
================================

# tt_sweep_ctrl

Sequencer that characterises one 4-input single-output combinational gate netlist by driving all 16 input vectors, waiting a programmable settle time per vector, and capturing the output into a 16-bit truth table. On completion it compares the captured table against an expected table and reports a match flag and a mismatch count. It sits between a host/test controller and one synthesized gate instance, owning that gate's input bus for the duration of a sweep.

## Interface
- SETTLE_CYCLES, default 4: number of extra cycles each vector is held before sampling; legal range 0..255.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request; accepted only in IDLE.
- abort  input  1  synchronous cancel of an in-progress sweep.
- expected_tt  input  16  expected truth table; captured on the accepted start edge.
- gate_out  input  1  output of the gate under control; synchronous to clk.
- gate_in  output  4  input vector driven to the gate; gate_in[0] drives gate input _0, up to gate_in[3] driving _3.
- busy  output  1  high in DRIVE.
- done  output  1  one-cycle pulse when a sweep completes.
- tt_out  output  16  captured truth table; bit i is gate_out sampled while gate_in == i.
- match  output  1  tt_out == captured expected_tt; valid from done onward.
- mismatch_cnt  output  5  popcount(tt_out ^ expected), range 0..16.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: gate_in = 0. If start = 1 at an edge: capture expected_tt, clear the working table, set idx = 0 and cnt = 0, and go to DRIVE. start is ignored in DRIVE and DONE.
- DRIVE: gate_in = idx.
  - At each edge with cnt < SETTLE_CYCLES: cnt++.
  - At the edge with cnt == SETTLE_CYCLES: working_tt[idx] <= gate_out and cnt <= 0.
    - If idx == 15, go to DONE.
    - Otherwise idx++.
- DONE, held for exactly one cycle:
  - done = 1.
  - tt_out, match and mismatch_cnt are updated from the working table and captured expected.
  - Next state is IDLE.
- tt_out, match and mismatch_cnt hold their values until the next DONE. They are never changed by start, abort or intermediate samples.
- abort = 1 in DRIVE:
  - Next state is IDLE and gate_in returns to 0.
  - No done pulse; results keep their prior values.
  - abort has no effect in IDLE or DONE.
- abort and start asserted together in IDLE: start wins.
- Counter widths: idx is 4 bits, cnt is 8 bits. mismatch_cnt is 5 bits so that the value 16 fits.

## Timing
- Reset values: state IDLE, gate_in = 0, busy = 0, done = 0, tt_out = 0, match = 0, mismatch_cnt = 0, idx = 0, cnt = 0, captured expected = 0.
- Reset mid-sweep: all of the above take effect immediately and asynchronously; no done pulse is produced.
- Per-vector timing: each vector is stable on gate_in for SETTLE_CYCLES+1 cycles. gate_out is sampled at the edge that ends the last of those cycles.
- Start to done: with the start edge as edge 0, DONE is entered at edge 16*(SETTLE_CYCLES+1). done is high during the cycle following that edge, and results are visible in that same cycle.
- busy is high from the cycle after the start edge through the last DRIVE cycle; it is low during DONE.
- Back-to-back sweeps: the earliest next accepted start is the edge after DONE, i.e. in the first IDLE cycle.
- SETTLE_CYCLES = 0: one cycle per vector; DONE is entered 16 cycles after start.

## Test plan
- Reset and idle: hold rst_n = 0, then release with no start -> gate_in = 0, busy = 0, done = 0, tt_out = 0, match = 0, mismatch_cnt = 0 for 50 cycles.
- AND4 sweep: bench gate model gate_out = &gate_in with 1-cycle settle, SETTLE_CYCLES = 4, expected_tt = 0x8000, pulse start -> gate_in steps 0..15, each held 5 cycles; done pulses exactly 80 cycles after the start edge; tt_out = 0x8000, match = 1, mismatch_cnt = 0.
- Mismatch: same model with expected_tt = 0x10C9 -> tt_out = 0x8000, match = 0, mismatch_cnt = 6.
- Abort: start, then abort during vector 7 -> return to IDLE next edge, gate_in = 0, no done pulse, tt_out/match unchanged from the previous sweep; a new start then completes normally.
- Ignored start: start re-asserted every cycle while busy -> exactly one done per sweep. A start in the DONE cycle is ignored; a start in the following cycle is accepted.
- Async reset mid-sweep at vector 10 -> outputs take reset values without waiting for a clock edge; no done pulse.

Source files
------------

// File: rtl/tt_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl_if
// Brief    : Host/gate-side bundle for the truth-table sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
interface tt_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] expected_tt;
  logic        gate_out;
  logic [3:0]  gate_in;
  logic        busy;
  logic        done;
  logic [15:0] tt_out;
  logic        match;
  logic [4:0]  mismatch_cnt;

  // The master side is the host together with the gate under control.
  modport master (
    output start, abort, expected_tt, gate_out,
    input  gate_in, busy, done, tt_out, match, mismatch_cnt
  );

  modport slave (
    input  start, abort, expected_tt, gate_out,
    output gate_in, busy, done, tt_out, match, mismatch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl
// Brief    : Drives all 16 vectors into a 4-input gate, captures its truth
//            table and scores it against an expected table.
// Revision : 1.0 - initial release
// ============================================================================
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  tt_sweep_ctrl_if.slave bus
);

  localparam logic [7:0] C_SETTLE = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [15:0] r_work;
  logic [15:0] r_exp;
  logic [3:0]  r_gate_in;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_tt;
  logic        r_match;
  logic [4:0]  r_mcnt;

  logic [15:0] w_work_nxt;
  logic [15:0] w_diff;
  logic [4:0]  w_pop;

  // Results are scored on the final sample edge so they appear with done.
  always_comb begin
    w_work_nxt        = r_work;
    w_work_nxt[r_idx] = bus.gate_out;
    w_diff            = w_work_nxt ^ r_exp;
    w_pop             = '0;
    for (int k = 0; k < 16; k++) begin
      w_pop = w_pop + {4'd0, w_diff[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_work    <= '0;
      r_exp     <= '0;
      r_gate_in <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tt      <= '0;
      r_match   <= 1'b0;
      r_mcnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_DRIVE;
            r_exp     <= bus.expected_tt;
            r_work    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_gate_in <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (bus.abort) begin
            r_state   <= S_IDLE;
            r_gate_in <= '0;
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
          end else if (r_cnt < C_SETTLE) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_work <= w_work_nxt;
            r_cnt  <= '0;
            if (r_idx == 4'd15) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_gate_in <= '0;
              r_done    <= 1'b1;
              r_tt      <= w_work_nxt;
              r_match   <= (w_diff == 16'd0);
              r_mcnt    <= w_pop;
              r_idx     <= '0;
            end else begin
              r_idx     <= r_idx + 4'd1;
              r_gate_in <= r_idx + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gate_in      = r_gate_in;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.tt_out       = r_tt;
  assign bus.match        = r_match;
  assign bus.mismatch_cnt = r_mcnt;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sweep_ctrl
// Brief    : Scoreboard bench for tt_sweep_ctrl against an AND4 gate model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_ctrl;

  localparam int SETTLE  = 4;
  localparam int LATENCY = 16 * (SETTLE + 1);

  typedef struct {
    logic [15:0] tt;
    logic        match;
    logic [4:0]  mcnt;
    int          stamp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   n_done;
  int   n_push;
  logic prev_done;
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t last_res;

  tt_sweep_ctrl_if bus ();

  tt_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // AND4 gate with one cycle of settle.
  always @(posedge clk) bus.gate_out <= &bus.gate_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] e, input int stamp);
    exp_t       r;
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v       = 4'(i);
      r.tt[i] = &v;
    end
    r.match = (r.tt == e);
    r.mcnt  = 5'($countones(r.tt ^ e));
    r.stamp = stamp;
    return r;
  endfunction

  function automatic logic [27:0] outs();
    return {bus.gate_in, bus.busy, bus.done, bus.tt_out, bus.match, bus.mismatch_cnt};
  endfunction

  // Returns at the negedge following the start edge.
  task automatic do_start(input logic [15:0] e, input bit push, input bit hold);
    @(negedge clk);
    bus.expected_tt = e;
    bus.start       = 1'b1;
    if (push) begin
      sb_q.push_back(model(e, cyc + 1));
      n_push++;
    end
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while (!bus.done && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("done_timeout", 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_vec(input logic [3:0] v, input string tag);
    int i;
    i = 0;
    while (bus.gate_in != v && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(bus.gate_in), 32'(v));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        n_done++;
        check("done_pulse_width", 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("tt_out", 32'(bus.tt_out), 32'(mon_e.tt));
          check("match", 32'(bus.match), 32'(mon_e.match));
          check("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(mon_e.mcnt));
          check("done_latency", 32'(cyc - mon_e.stamp), 32'(LATENCY));
          check("busy_in_done", 32'(bus.busy), 32'd0);
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc         = 0;
    n_tests     = 0;
    n_fail      = 0;
    n_done      = 0;
    n_push      = 0;
    prev_done   = 1'b0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.expected_tt = '0;

    // Reset and idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'(outs()), 32'd0);
    end

    // AND4 sweep with per-vector stepping checks
    do_start(16'h8000, 1'b1, 1'b0);
    for (int k = 0; k < LATENCY; k++) begin
      check("gate_in_step", 32'(bus.gate_in), 32'(k / (SETTLE + 1)));
      check("busy_drive", 32'(bus.busy), 32'd1);
      if (k != LATENCY - 1) @(negedge clk);
    end
    @(negedge clk);
    wait_done(5);
    check("gate_in_after_done", 32'(bus.gate_in), 32'd0);

    // Mismatch sweep
    do_start(16'h10C9, 1'b1, 1'b0);
    wait_done(LATENCY + 10);
    last_res = model(16'h10C9, 0);

    // Abort during vector 7
    do_start(16'h8000, 1'b0, 1'b0);
    wait_vec(4'd7, "abort_reach_v7");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_gate_in", 32'(bus.gate_in), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (100) @(negedge clk);
    check("abort_tt_hold", 32'(bus.tt_out), 32'(last_res.tt));
    check("abort_match_hold", 32'(bus.match), 32'(last_res.match));
    check("abort_mcnt_hold", 32'(bus.mismatch_cnt), 32'(last_res.mcnt));
    do_start(16'hFFFF, 1'b1, 1'b0);
    wait_done(LATENCY + 10);

    // Start held high: ignored while busy and in DONE, taken in first IDLE cycle
    do_start(16'h8001, 1'b1, 1'b1);
    wait_done(LATENCY + 10);
    check("idle_after_done_busy", 32'(bus.busy), 32'd0);
    bus.expected_tt = 16'h0000;
    sb_q.push_back(model(16'h0000, cyc + 1));
    n_push++;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(LATENCY + 10);

    // Asynchronous reset mid-sweep at vector 10
    do_start(16'hA5A5, 1'b0, 1'b0);
    wait_vec(4'd10, "reset_reach_v10");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_reset_idle", 32'(outs()), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_push));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
